// File: rtl/div_seq_ctrl.sv
// Multi-cycle radix-2 restoring divide sequencer for DIV/DIVU in EX; returns {remainder, quotient}.
// Optional macro DIV_ZERO_FLAG_EN adds the div_zero_o flag output and its register.
module div_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic               div_zero_o
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1'b1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_FREE   = 2'b00,
        ST_BYZERO = 2'b01,
        ST_ON     = 2'b10,
        ST_END    = 2'b11
    } state_t;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        logic [WIDTH-1:0] r;
        if (neg) begin
            r = ~v + ONE;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t             state_r, state_nxt_s;
    logic [CW-1:0]      cnt_r, cnt_nxt_s;
    logic [WIDTH-1:0]   rem_r, rem_nxt_s;
    logic [WIDTH-1:0]   quo_r, quo_nxt_s;
    logic [WIDTH-1:0]   dvs_r, dvs_nxt_s;
    logic               neg_q_r, neg_q_nxt_s;
    logic               neg_rem_r, neg_rem_nxt_s;
    logic               ready_r, ready_nxt_s;
    logic [2*WIDTH-1:0] result_r, result_nxt_s;

    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     trial_s;
    logic               borrow_s;
    logic [WIDTH-1:0]   step_rem_s;
    logic [WIDTH-1:0]   step_quo_s;
    logic               accept_s;
    logic               sign1_s;
    logic               sign2_s;

    // One restoring step: the dividend register shifts out into the partial remainder
    // while quotient bits shift in from the bottom.
    always_comb begin
        shifted_s  = {rem_r, quo_r[WIDTH-1]};
        trial_s    = shifted_s - {1'b0, dvs_r};
        borrow_s   = trial_s[WIDTH];
        step_quo_s = {quo_r[WIDTH-2:0], ~borrow_s};
        if (borrow_s) begin
            step_rem_s = shifted_s[WIDTH-1:0];
        end else begin
            step_rem_s = trial_s[WIDTH-1:0];
        end
    end

    assign accept_s = start_i & ~annul_i;
    assign sign1_s  = signed_div_i & opdata1_i[WIDTH-1];
    assign sign2_s  = signed_div_i & opdata2_i[WIDTH-1];

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        rem_nxt_s     = rem_r;
        quo_nxt_s     = quo_r;
        dvs_nxt_s     = dvs_r;
        neg_q_nxt_s   = neg_q_r;
        neg_rem_nxt_s = neg_rem_r;
        ready_nxt_s   = ready_r;
        result_nxt_s  = result_r;
        case (state_r)
            ST_FREE: begin
                ready_nxt_s  = 1'b0;
                result_nxt_s = {(2*WIDTH){1'b0}};
                if (accept_s && (opdata2_i == {WIDTH{1'b0}})) begin
                    state_nxt_s = ST_BYZERO;
                end else if (accept_s) begin
                    state_nxt_s   = ST_ON;
                    cnt_nxt_s     = {CW{1'b0}};
                    rem_nxt_s     = {WIDTH{1'b0}};
                    quo_nxt_s     = cond_neg(opdata1_i, sign1_s);
                    dvs_nxt_s     = cond_neg(opdata2_i, sign2_s);
                    neg_q_nxt_s   = sign1_s ^ sign2_s;
                    neg_rem_nxt_s = sign1_s;
                end else begin
                    state_nxt_s = ST_FREE;
                end
            end
            ST_BYZERO: begin
                if (annul_i) begin
                    state_nxt_s = ST_FREE;
                end else begin
                    state_nxt_s = ST_END;
                    rem_nxt_s   = {WIDTH{1'b0}};
                    quo_nxt_s   = {WIDTH{1'b0}};
                end
            end
            ST_ON: begin
                if (annul_i) begin
                    state_nxt_s = ST_FREE;
                    cnt_nxt_s   = {CW{1'b0}};
                end else if (cnt_r == LAST_CNT) begin
                    // Final step also restores the operand signs.
                    state_nxt_s = ST_END;
                    cnt_nxt_s   = {CW{1'b0}};
                    rem_nxt_s   = cond_neg(step_rem_s, neg_rem_r);
                    quo_nxt_s   = cond_neg(step_quo_s, neg_q_r);
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                    rem_nxt_s = step_rem_s;
                    quo_nxt_s = step_quo_s;
                end
            end
            ST_END: begin
                if (!start_i || annul_i) begin
                    state_nxt_s  = ST_FREE;
                    ready_nxt_s  = 1'b0;
                    result_nxt_s = {(2*WIDTH){1'b0}};
                end else begin
                    ready_nxt_s  = 1'b1;
                    result_nxt_s = {rem_r, quo_r};
                end
            end
            default: begin
                state_nxt_s  = ST_FREE;
                ready_nxt_s  = 1'b0;
                result_nxt_s = {(2*WIDTH){1'b0}};
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= ST_FREE;
            cnt_r     <= {CW{1'b0}};
            rem_r     <= {WIDTH{1'b0}};
            quo_r     <= {WIDTH{1'b0}};
            dvs_r     <= {WIDTH{1'b0}};
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            ready_r   <= 1'b0;
            result_r  <= {(2*WIDTH){1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            rem_r     <= rem_nxt_s;
            quo_r     <= quo_nxt_s;
            dvs_r     <= dvs_nxt_s;
            neg_q_r   <= neg_q_nxt_s;
            neg_rem_r <= neg_rem_nxt_s;
            ready_r   <= ready_nxt_s;
            result_r  <= result_nxt_s;
        end
    end

    assign result_o   = result_r;
    assign ready_o    = ready_r;
    assign stallreq_o = start_i & ~ready_r;

`ifdef DIV_ZERO_FLAG_EN
    logic dz_r;

    // Zero-divisor flag: raised on acceptance, dropped whenever the FSM returns to FREE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dz_r <= 1'b0;
        end else if ((state_r == ST_FREE) && accept_s && (opdata2_i == {WIDTH{1'b0}})) begin
            dz_r <= 1'b1;
        end else if (state_nxt_s == ST_FREE) begin
            dz_r <= 1'b0;
        end else begin
            dz_r <= dz_r;
        end
    end

    assign div_zero_o = dz_r;
`endif

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: cycle model with plain arithmetic plus directed literal cases.
module tb_div_seq_ctrl;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          signed_div_i = 1'b0;
    logic [W-1:0]  opdata1_i = '0;
    logic [W-1:0]  opdata2_i = '0;
    logic          start_i = 1'b0;
    logic          annul_i = 1'b0;
    logic [2*W-1:0] result_o;
    logic          ready_o;
    logic          stallreq_o;
`ifdef DIV_ZERO_FLAG_EN
    logic          div_zero_o;
`endif

    div_seq_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
`ifdef DIV_ZERO_FLAG_EN
        ,
        .div_zero_o   (div_zero_o)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    endtask

    task automatic check1(input string name, input logic got, input logic want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
    endtask

    // Expected {remainder, quotient} straight from arithmetic.
    function automatic logic [63:0] exp_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        int sa;
        int sb;
        if (b == 32'd0) return 64'd0;
        if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            sa = a;
            sb = b;
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
        return {r, q};
    endfunction

    // Behavioural timing model: idle / busy-countdown / done.
    typedef enum {M_IDLE, M_BUSY, M_DONE} mmode_t;
    mmode_t      m_mode = M_IDLE;
    int          m_wait = 0;
    logic [63:0] m_res = '0;
    logic [63:0] exp_result = '0;
    logic        exp_ready = 1'b0;
    logic        exp_dz = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_mode <= M_IDLE; exp_ready <= 1'b0; exp_result <= '0; exp_dz <= 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    exp_ready <= 1'b0; exp_result <= '0; exp_dz <= 1'b0;
                    if (start_i && !annul_i) begin
                        m_res  <= exp_div(signed_div_i, opdata1_i, opdata2_i);
                        m_wait <= (opdata2_i == 32'd0) ? 1 : W;
                        exp_dz <= (opdata2_i == 32'd0);
                        m_mode <= M_BUSY;
                    end
                end
                M_BUSY: begin
                    if (annul_i) begin
                        m_mode <= M_IDLE; exp_dz <= 1'b0;
                    end else if (m_wait == 1) m_mode <= M_DONE;
                    else m_wait <= m_wait - 1;
                end
                M_DONE: begin
                    if (!start_i || annul_i) begin
                        m_mode <= M_IDLE; exp_ready <= 1'b0; exp_result <= '0; exp_dz <= 1'b0;
                    end else begin
                        exp_ready <= 1'b1; exp_result <= m_res;
                    end
                end
                default: m_mode <= M_IDLE;
            endcase
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check1("ready", ready_o, exp_ready);
            check("result", result_o, exp_result);
            check1("stall", stallreq_o, start_i & ~exp_ready);
`ifdef DIV_ZERO_FLAG_EN
            check1("div_zero", div_zero_o, exp_dz);
`endif
        end
    end

    // Start an op (optionally without waiting a cycle first), wait for ready, check latency and result.
    task automatic do_op(input bit no_wait, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [63:0] exp_res, input string nm);
        int n;
        bit got;
        if (!no_wait) begin
            @(posedge clk); #1;
        end
        signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1; annul_i = 1'b0;
        n = 0; got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(posedge clk); n++;
            #1 opdata1_i = $urandom; opdata2_i = $urandom;
            @(negedge clk);
            if (ready_o) got = 1'b1;
        end
        check1({nm, "_ready"}, got, 1'b1);
        check({nm, "_latency"}, 64'(n - 1), 64'(exp_lat));
        check({nm, "_result"}, result_o, exp_res);
        check1({nm, "_stall"}, stallreq_o, 1'b0);
    endtask

    task automatic drop_start();
        @(posedge clk); #1 start_i = 1'b0; annul_i = 1'b0;
    endtask

    int ready_seen;

    initial begin
        rst = 1'b0;
        @(posedge clk); #1 check_en = 1'b1;
        @(negedge clk);
        check("reset_result", result_o, 64'd0);
        check1("reset_ready", ready_o, 1'b0);
        @(posedge clk); #1 rst = 1'b1;

        // Directed cases with hand-computed literals.
        do_op(1'b0, 1'b0, 32'd100, 32'd7, W + 1, {32'd2, 32'd14}, "divu_100_7");
        drop_start();
        do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, W + 1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_m7_2");
        drop_start();
        do_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, W + 1, {32'h1, 32'hFFFF_FFFD}, "div_7_m2");
        drop_start();
        do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, W + 1, {32'h0, 32'h8000_0000}, "div_ovf");
        drop_start();
        do_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, W + 1, {32'h0, 32'hFFFF_FFFF}, "divu_max_1");
        drop_start();
        do_op(1'b0, 1'b0, 32'd123, 32'd0, 2, 64'd0, "div_zero");
`ifdef DIV_ZERO_FLAG_EN
        check1("div_zero_flag", div_zero_o, 1'b1);
`endif
        drop_start();

        // Annul at cnt=10: the op must never complete.
        @(posedge clk); #1 signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        repeat (11) @(posedge clk);
        #1 annul_i = 1'b1;
        drop_start();
        ready_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) ready_seen++;
        end
        check("annul_no_ready", 64'(ready_seen), 64'd0);

        // Reset at cnt=20, then a clean restart.
        @(posedge clk); #1 opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        repeat (21) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check1("midrst_ready", ready_o, 1'b0);
        check("midrst_result", result_o, 64'd0);
        @(posedge clk); #1 rst = 1'b1; start_i = 1'b0;
        do_op(1'b0, 1'b0, 32'd100, 32'd7, W + 1, {32'd2, 32'd14}, "restart");

        // Hold start in END, then back-to-back restart one cycle after FREE.
        repeat (5) begin
            @(negedge clk);
            check("hold_result", result_o, {32'd2, 32'd14});
            check1("hold_ready", ready_o, 1'b1);
        end
        @(posedge clk); #1 start_i = 1'b0;
        @(posedge clk); #1;
        check1("drop_ready", ready_o, 1'b0);
        do_op(1'b1, 1'b0, 32'd1000, 32'd33, W + 1, {32'd10, 32'd30}, "b2b");
        drop_start();

        // Randomized operations against the model.
        for (int i = 0; i < 30; i++) begin
            logic s;
            logic [31:0] a;
            logic [31:0] b;
            int abort_at;
            bit abort;
            bit done;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = 32'hFFFF_FFFF;
                3: begin a = 32'h8000_0000; b = $urandom; end
                default: b = $urandom;
            endcase
            abort = ($urandom_range(0, 5) == 0);
            abort_at = $urandom_range(0, W);
            @(posedge clk); #1 signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
            done = 1'b0;
            for (int k = 0; k < 100 && !done; k++) begin
                @(posedge clk);
                #1 opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = 1'($urandom_range(0, 1));
                if (abort && k == abort_at) annul_i = 1'b1;
                @(negedge clk);
                if (ready_o || annul_i) done = 1'b1;
            end
            check1("rand_done", done, 1'b1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1 annul_i = 1'b1;
            end
            drop_start();
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
